// File: rtl/fp_round_pack.sv
// Rounding/packing stage: normalise an unpacked {sign, exp, frac}, round per MIPS RM,
// pack to IEEE-754 with inexact/overflow/underflow flags. Pipeline st0 -> st1 -> out.
module fp_round_pack #(
    parameter int exp_width  = 11,
    parameter int frac_width = 52,
    parameter int info_width = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic                                a_wait,
    output logic                                busy,
    input  logic                                in_sign,
    input  logic [exp_width+1:0]                in_exp,
    input  logic [2*frac_width+3:0]             in_frac,
    input  logic [1:0]                          rm,
    input  logic [info_width-1:0]               info_in,
    output logic [info_width-1:0]               info_out,
    output logic [exp_width+frac_width:0]       result,
    output logic                                flag_inexact,
    output logic                                flag_overflow,
    output logic                                flag_underflow
);

    localparam int EW = exp_width;
    localparam int FW = frac_width;
    localparam int IW = info_width;
    localparam int XW = exp_width + 3;

    localparam logic [1:0] RM_RN = 2'b00;
    localparam logic [1:0] RM_RZ = 2'b01;
    localparam logic [1:0] RM_RP = 2'b10;
    localparam logic [1:0] RM_RM = 2'b11;

    localparam logic signed [XW-1:0] EXP_SAT  = {3'b000, {EW{1'b1}}};
    localparam logic signed [XW-1:0] EXP_ZERO = {XW{1'b0}};

    function automatic logic round_inc(input logic [1:0] mode, input logic sgn,
                                       input logic lsb, input logic g, input logic s);
        logic inc;
        case (mode)
            RM_RN:   inc = g & (s | lsb);
            RM_RZ:   inc = 1'b0;
            RM_RP:   inc = ~sgn & (g | s);
            RM_RM:   inc = sgn & (g | s);
            default: inc = 1'b0;
        endcase
        return inc;
    endfunction

    // Sideband advance: stall holds everything, flush still drops the valid bit.
    function automatic logic [IW-1:0] info_step(input logic [IW-1:0] cur, input logic [IW-1:0] nxt,
                                                input logic fl, input logic wt);
        logic [IW-1:0] r;
        r    = wt ? cur : nxt;
        r[0] = fl ? 1'b0 : r[0];
        return r;
    endfunction

    logic signed [XW-1:0] exp_ext_s;
    logic signed [XW-1:0] exp_norm_s;
    logic [FW-1:0]        frac_norm_s;
    logic                 guard_s;
    logic                 sticky_s;
    logic                 zero_s;

    logic                 s0_sign_r;
    logic signed [XW-1:0] s0_exp_r;
    logic [FW-1:0]        s0_frac_r;
    logic                 s0_guard_r;
    logic                 s0_sticky_r;
    logic                 s0_zero_r;
    logic [1:0]           s0_rm_r;
    logic [IW-1:0]        s0_info_r;

    logic                 inc_s;
    logic                 carry_s;
    logic [FW-1:0]        frac_sum_s;
    logic signed [XW-1:0] exp_rnd_s;
    logic [FW-1:0]        frac_rnd_s;

    logic                 s1_sign_r;
    logic signed [XW-1:0] s1_exp_r;
    logic [FW-1:0]        s1_frac_r;
    logic                 s1_inexact_r;
    logic                 s1_zero_r;
    logic [1:0]           s1_rm_r;
    logic [IW-1:0]        s1_info_r;

    logic                 to_inf_s;
    logic [EW+FW:0]       pk_res_s;
    logic                 pk_ix_s;
    logic                 pk_ov_s;
    logic                 pk_uf_s;

    logic [EW+FW:0]       result_r;
    logic [IW-1:0]        info_out_r;
    logic                 inexact_r;
    logic                 overflow_r;
    logic                 underflow_r;

    // Normalise: bits shifted out fold into the sticky OR below the guard bit.
    always_comb begin
        exp_ext_s = {in_exp[EW+1], in_exp};
        zero_s    = (in_frac == '0);
        if (in_frac[2*FW+3]) begin
            exp_norm_s  = exp_ext_s + XW'(2'd2);
            frac_norm_s = in_frac[2*FW+2:FW+3];
            guard_s     = in_frac[FW+2];
            sticky_s    = |in_frac[FW+1:0];
        end else if (in_frac[2*FW+2]) begin
            exp_norm_s  = exp_ext_s + XW'(2'd1);
            frac_norm_s = in_frac[2*FW+1:FW+2];
            guard_s     = in_frac[FW+1];
            sticky_s    = |in_frac[FW:0];
        end else begin
            exp_norm_s  = exp_ext_s;
            frac_norm_s = in_frac[2*FW:FW+1];
            guard_s     = in_frac[FW];
            sticky_s    = |in_frac[FW-1:0];
        end
    end

    // st0 register: normalised operand.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_sign_r   <= 1'b0;
            s0_exp_r    <= '0;
            s0_frac_r   <= '0;
            s0_guard_r  <= 1'b0;
            s0_sticky_r <= 1'b0;
            s0_zero_r   <= 1'b0;
            s0_rm_r     <= 2'b00;
            s0_info_r   <= '0;
        end else begin
            if (!a_wait) begin
                s0_sign_r   <= in_sign;
                s0_exp_r    <= exp_norm_s;
                s0_frac_r   <= frac_norm_s;
                s0_guard_r  <= guard_s;
                s0_sticky_r <= sticky_s;
                s0_zero_r   <= zero_s;
                s0_rm_r     <= rm;
            end
            s0_info_r <= info_step(s0_info_r, info_in, flush, a_wait);
        end
    end

    // Round: a carry out of the all-ones fraction bumps the hidden bit into the exponent.
    always_comb begin
        inc_s                 = round_inc(s0_rm_r, s0_sign_r, s0_frac_r[0], s0_guard_r, s0_sticky_r);
        {carry_s, frac_sum_s} = {1'b0, s0_frac_r} + {{FW{1'b0}}, inc_s};
        if (carry_s) begin
            exp_rnd_s  = s0_exp_r + XW'(1'b1);
            frac_rnd_s = '0;
        end else begin
            exp_rnd_s  = s0_exp_r;
            frac_rnd_s = frac_sum_s;
        end
    end

    // st1 register: rounded operand.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_sign_r    <= 1'b0;
            s1_exp_r     <= '0;
            s1_frac_r    <= '0;
            s1_inexact_r <= 1'b0;
            s1_zero_r    <= 1'b0;
            s1_rm_r      <= 2'b00;
            s1_info_r    <= '0;
        end else begin
            if (!a_wait) begin
                s1_sign_r    <= s0_sign_r;
                s1_exp_r     <= exp_rnd_s;
                s1_frac_r    <= frac_rnd_s;
                s1_inexact_r <= s0_guard_r | s0_sticky_r;
                s1_zero_r    <= s0_zero_r;
                s1_rm_r      <= s0_rm_r;
            end
            s1_info_r <= info_step(s1_info_r, s0_info_r, flush, a_wait);
        end
    end

    // Pack with range check on the post-rounding exponent.
    always_comb begin
        to_inf_s = (s1_rm_r == RM_RN) | ((s1_rm_r == RM_RP) & ~s1_sign_r) |
                   ((s1_rm_r == RM_RM) & s1_sign_r);
        if (s1_zero_r) begin
            pk_res_s = {s1_sign_r, {(EW+FW){1'b0}}};
            pk_ix_s  = 1'b0;
            pk_ov_s  = 1'b0;
            pk_uf_s  = 1'b0;
        end else if (s1_exp_r >= EXP_SAT) begin
            if (to_inf_s) begin
                pk_res_s = {s1_sign_r, {EW{1'b1}}, {FW{1'b0}}};
            end else begin
                pk_res_s = {s1_sign_r, {(EW-1){1'b1}}, 1'b0, {FW{1'b1}}};
            end
            pk_ix_s = 1'b1;
            pk_ov_s = 1'b1;
            pk_uf_s = 1'b0;
        end else if (s1_exp_r <= EXP_ZERO) begin
            pk_res_s = {s1_sign_r, {(EW+FW){1'b0}}};
            pk_ix_s  = 1'b1;
            pk_ov_s  = 1'b0;
            pk_uf_s  = 1'b1;
        end else begin
            pk_res_s = {s1_sign_r, s1_exp_r[EW-1:0], s1_frac_r};
            pk_ix_s  = s1_inexact_r;
            pk_ov_s  = 1'b0;
            pk_uf_s  = 1'b0;
        end
    end

    // Output register: flags only survive alongside a valid result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_r    <= '0;
            info_out_r  <= '0;
            inexact_r   <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (!a_wait) begin
                result_r <= pk_res_s;
            end
            if (flush) begin
                inexact_r   <= 1'b0;
                overflow_r  <= 1'b0;
                underflow_r <= 1'b0;
            end else if (!a_wait) begin
                inexact_r   <= pk_ix_s & s1_info_r[0];
                overflow_r  <= pk_ov_s & s1_info_r[0];
                underflow_r <= pk_uf_s & s1_info_r[0];
            end else begin
                inexact_r   <= inexact_r;
                overflow_r  <= overflow_r;
                underflow_r <= underflow_r;
            end
            info_out_r <= info_step(info_out_r, s1_info_r, flush, a_wait);
        end
    end

    assign busy           = a_wait;
    assign result         = result_r;
    assign info_out       = info_out_r;
    assign flag_inexact   = inexact_r;
    assign flag_overflow  = overflow_r;
    assign flag_underflow = underflow_r;

endmodule

// File: tb/tb_fp_round_pack.sv
// Directed bench for fp_round_pack, single-precision instance with a 2-bit sideband.
module tb_fp_round_pack;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        a_wait;
    logic        busy;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [49:0] in_frac;
    logic [1:0]  rm;
    logic [1:0]  info_in;
    logic [1:0]  info_out;
    logic [31:0] result;
    logic        flag_inexact;
    logic        flag_overflow;
    logic        flag_underflow;

    int n_chk = 0;
    int n_err = 0;

    fp_round_pack #(.exp_width(8), .frac_width(23), .info_width(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .a_wait         (a_wait),
        .busy           (busy),
        .in_sign        (in_sign),
        .in_exp         (in_exp),
        .in_frac        (in_frac),
        .rm             (rm),
        .info_in        (info_in),
        .info_out       (info_out),
        .result         (result),
        .flag_inexact   (flag_inexact),
        .flag_overflow  (flag_overflow),
        .flag_underflow (flag_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic s, input logic [9:0] e, input logic [49:0] f,
                         input logic [1:0] mode, input logic [1:0] info);
        in_sign = s;
        in_exp  = e;
        in_frac = f;
        rm      = mode;
        info_in = info;
    endtask

    task automatic idle();
        drive(1'b0, 10'd0, 50'd0, 2'b00, 2'b00);
    endtask

    task automatic chk_out(input string tag, input logic [31:0] res, input logic [2:0] flg,
                           input logic [1:0] info);
        chk({tag, ".res"}, result, res);
        chk({tag, ".flags"}, {flag_inexact, flag_overflow, flag_underflow}, flg);
        chk({tag, ".info"}, info_out, info);
    endtask

    // One isolated operation; flags are {inexact, overflow, underflow}.
    task automatic run_one(input string tag, input logic s, input logic [9:0] e,
                           input logic [49:0] f, input logic [1:0] mode,
                           input logic [31:0] res, input logic [2:0] flg);
        @(negedge clk);
        drive(s, e, f, mode, 2'b01);
        @(posedge clk);
        @(negedge clk);
        idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_out(tag, res, flg, 2'b01);
    endtask

    initial begin
        reset  = 1'b1;
        flush  = 1'b0;
        a_wait = 1'b0;
        idle();
        #12;
        chk_out("reset", 32'h0000_0000, 3'b000, 2'b00);
        chk("busy_idle", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        run_one("cvt_rn",   1'b0, 10'd151, 50'h0_8000_0080_0000, 2'b00, 32'h4B80_0000, 3'b100);
        run_one("cvt_rp",   1'b0, 10'd151, 50'h0_8000_0080_0000, 2'b10, 32'h4B80_0001, 3'b100);
        run_one("carry_ov", 1'b0, 10'd254, 50'h0_FFFF_FF80_0000, 2'b00, 32'h7F80_0000, 3'b110);
        run_one("max_rz",   1'b0, 10'd254, 50'h0_FFFF_FF80_0000, 2'b01, 32'h7F7F_FFFF, 3'b100);
        run_one("uf_neg",   1'b1, 10'd0,   50'h0_8000_0000_0000, 2'b00, 32'h8000_0000, 3'b101);
        run_one("zero",     1'b0, 10'd77,  50'h0_0000_0000_0000, 2'b00, 32'h0000_0000, 3'b000);
        run_one("norm1",    1'b0, 10'd127, 50'h1_4000_0000_0000, 2'b00, 32'h4020_0000, 3'b000);
        run_one("norm2",    1'b0, 10'd127, 50'h2_0000_0000_0000, 2'b00, 32'h4080_0000, 3'b000);
        run_one("norm2_st", 1'b0, 10'd127, 50'h2_0000_0000_0001, 2'b10, 32'h4080_0001, 3'b100);
        run_one("ov_rm_p",  1'b0, 10'd255, 50'h0_8000_0000_0000, 2'b11, 32'h7F7F_FFFF, 3'b110);
        run_one("ov_rm_n",  1'b1, 10'd255, 50'h0_8000_0000_0000, 2'b11, 32'hFF80_0000, 3'b110);
        run_one("uf_mexp",  1'b0, 10'h3FB, 50'h0_8000_0000_0000, 2'b00, 32'h0000_0000, 3'b101);

        // Back-to-back stream with a two-cycle stall once the first op reaches the output.
        @(negedge clk);
        drive(1'b0, 10'd127, 50'h1_4000_0000_0000, 2'b00, 2'b11);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 10'd127, 50'h2_0000_0000_0000, 2'b00, 2'b01);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 10'd151, 50'h0_8000_0080_0000, 2'b10, 2'b11);
        @(posedge clk);
        #1;
        chk_out("str_a", 32'h4020_0000, 3'b000, 2'b11);
        @(negedge clk);
        idle();
        a_wait = 1'b1;
        @(posedge clk);
        #1;
        chk_out("stall1", 32'h4020_0000, 3'b000, 2'b11);
        chk("busy_stall", busy, 1'b1);
        @(posedge clk);
        #1;
        chk_out("stall2", 32'h4020_0000, 3'b000, 2'b11);
        @(negedge clk);
        a_wait = 1'b0;
        @(posedge clk);
        #1;
        chk_out("str_b", 32'h4080_0000, 3'b000, 2'b01);
        @(posedge clk);
        #1;
        chk_out("str_c", 32'h4B80_0001, 3'b100, 2'b11);

        // Flush while three ops are in flight: data still drains, valid and flags do not.
        @(negedge clk);
        drive(1'b0, 10'd127, 50'h1_4000_0000_0000, 2'b00, 2'b11);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 10'd127, 50'h2_0000_0000_0001, 2'b10, 2'b11);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 10'd151, 50'h0_8000_0080_0000, 2'b10, 2'b11);
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk_out("fl_a", 32'h4020_0000, 3'b000, 2'b10);
        @(negedge clk);
        flush = 1'b0;
        idle();
        @(posedge clk);
        #1;
        chk_out("fl_b", 32'h4080_0001, 3'b000, 2'b10);
        @(posedge clk);
        #1;
        chk_out("fl_c", 32'h4B80_0001, 3'b000, 2'b10);

        // Asynchronous reset with two ops still inside the pipe.
        @(negedge clk);
        drive(1'b0, 10'd127, 50'h1_4000_0000_0000, 2'b00, 2'b01);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 10'd151, 50'h0_8000_0080_0000, 2'b10, 2'b01);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 10'd255, 50'h0_8000_0000_0000, 2'b00, 2'b01);
        @(posedge clk);
        #1;
        chk_out("rst_pre", 32'h4020_0000, 3'b000, 2'b01);
        idle();
        #2;
        reset = 1'b1;
        #1;
        chk_out("rst_now", 32'h0000_0000, 3'b000, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk_out($sformatf("rst_after%0d", i), 32'h0000_0000, 3'b000, 2'b00);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
